// File: rtl/neopx_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : neopx_frame_streamer
//  Purpose  : Wishbone-loaded pixel RAM streamed as GRB words over AXIS, with a
//             latch gap after each frame. Optional macro NEOPX_BRIGHTNESS_EN
//             enables per-byte brightness scaling.
//  Revision : 1.0 - initial release
// ============================================================================
module neopx_frame_streamer #(
    parameter int NUM_PX       = 8,
    parameter int LATCH_CYCLES = 21600
) (
    input  logic        axis_aclk,
    input  logic        axis_reset,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [23:0] m_axis_data,
    output logic        m_axis_valid,
    input  logic        m_axis_ready,
    output logic        o_busy
);
    localparam int IDX_W = (NUM_PX > 1) ? $clog2(NUM_PX) : 1;
    localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(NUM_PX - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [4:0]       c_ADR_CTRL   = 5'h10;
    localparam logic [4:0]       c_ADR_BRIGHT = 5'h11;
    localparam logic [4:0]       c_ADR_NPX    = 5'(NUM_PX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_valid;
    logic [23:0]      r_data;
    logic             r_seen;
    logic             r_ack;
    logic [31:0]      r_dat_o;
    logic [23:0]      r_px [NUM_PX];

    logic             w_accept;
    logic             w_px_sel;
    logic             w_px_wr;
    logic             w_start;
    logic             w_consume;
    logic [IDX_W-1:0] w_adr_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_load_idx;
    logic [23:0]      w_load_px;
    logic [23:0]      w_load_data;
    logic [31:0]      w_rd_data;
    logic             w_unused;

    // Only the first cycle of a held strobe is an access; r_seen masks the rest.
    assign w_accept  = wb_cyc_i & wb_stb_i & ~r_seen;
    assign w_px_sel  = (wb_adr_i < c_ADR_NPX);
    assign w_adr_idx = wb_adr_i[IDX_W-1:0];
    assign w_px_wr   = w_accept & wb_we_i & w_px_sel;
    assign w_start   = w_accept & wb_we_i & (wb_adr_i == c_ADR_CTRL) & wb_dat_i[0];
    assign w_consume = (r_state == ST_LATCH) & (r_cnt == c_CNT_LAST) & r_pending;
    assign w_idx_nxt = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
    assign w_load_idx = (r_state == ST_SEND) ? w_idx_nxt : '0;
    assign w_load_px  = r_px[w_load_idx];
    assign w_unused   = &{1'b0, wb_dat_i[31:24]};

    assign o_busy       = (r_state != ST_IDLE);
    assign m_axis_valid = r_valid;
    assign m_axis_data  = r_data;
    assign wb_ack_o     = r_ack;
    assign wb_dat_o     = r_dat_o;

`ifdef NEOPX_BRIGHTNESS_EN
    logic [7:0] r_bright;

    function automatic logic [7:0] f_scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'h00, c} * ({8'h00, b} + 16'd1);
        return p[15:8];
    endfunction

    assign w_load_data = {f_scale(w_load_px[23:16], r_bright),
                          f_scale(w_load_px[15:8],  r_bright),
                          f_scale(w_load_px[7:0],   r_bright)};

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            r_bright <= 8'hFF;
        end else if (w_accept && wb_we_i && (wb_adr_i == c_ADR_BRIGHT)) begin
            r_bright <= wb_dat_i[7:0];
        end
    end
`else
    assign w_load_data = w_load_px;
`endif

    always_comb begin
        w_rd_data = '0;
        if (w_px_sel) begin
            w_rd_data = {8'h00, r_px[w_adr_idx]};
        end else if (wb_adr_i == c_ADR_CTRL) begin
            w_rd_data = {30'd0, o_busy, r_pending};
        end
`ifdef NEOPX_BRIGHTNESS_EN
        else if (wb_adr_i == c_ADR_BRIGHT) begin
            w_rd_data = {24'd0, r_bright};
        end
`endif
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            r_seen  <= 1'b0;
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_seen <= wb_cyc_i & wb_stb_i;
            r_ack  <= w_accept;
            if (w_accept) begin
                r_dat_o <= w_rd_data;
            end
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            for (int i = 0; i < NUM_PX; i++) begin
                r_px[i] <= '0;
            end
        end else if (w_px_wr) begin
            r_px[w_adr_idx] <= wb_dat_i[23:0];
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else begin
            // A start arriving while busy is remembered once; the exit edge may re-arm it.
            r_pending <= (r_pending & ~w_consume) | (w_start & (r_state != ST_IDLE));
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_SEND;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_data  <= w_load_data;
                    end
                end
                ST_SEND: begin
                    if (r_valid && m_axis_ready) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= ST_LATCH;
                            r_valid <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_idx  <= w_idx_nxt;
                            r_data <= w_load_data;
                        end
                    end
                end
                ST_LATCH: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_idx <= '0;
                        if (r_pending) begin
                            r_state <= ST_SEND;
                            r_valid <= 1'b1;
                            r_data  <= w_load_data;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neopx_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neopx_frame_streamer
//  Purpose  : Self-checking bench for neopx_frame_streamer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_neopx_frame_streamer;
    localparam int NPX = 8;
    localparam int LAT = 16;
`ifdef NEOPX_BRIGHTNESS_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        axis_reset = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [4:0]  wb_adr = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [23:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready = 1'b0;
    logic        o_busy;

    neopx_frame_streamer #(.NUM_PX(NPX), .LATCH_CYCLES(LAT)) dut (
        .axis_aclk(clk), .axis_reset(axis_reset),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [23:0] m_px [NPX];
    logic [7:0]  m_bright = 8'hFF;
    int rdy_mode = 3;
    logic man_ready = 1'b0;
    int bif = 0, beats_total = 0, busy_cycles = 0, busy_runs = 0;
    logic [23:0] rec [NPX];
    logic pv = 0, pr = 0, pb = 0;
    logic [23:0] pd = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_px(input int k);
        logic [23:0] p;
        p = m_px[k];
        if (BR_EN) begin
            for (int b = 0; b < 3; b++) begin
                p[b*8 +: 8] = 8'((int'(m_px[k][b*8 +: 8]) * (int'(m_bright) + 1)) / 256);
            end
        end
        return p;
    endfunction

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_axis_ready = 1'b1;
                1:       m_axis_ready = ~m_axis_ready;
                2:       m_axis_ready = 1'($urandom_range(0, 1));
                default: m_axis_ready = man_ready;
            endcase
        end
    end

    // Stream monitor: transfers are decided by values stable at the falling edge.
    always @(negedge clk) begin
        if (axis_reset) begin
            bif = 0; pv = 0; pb = 0;
        end else begin
            if (pv && !pr) begin
                chk("stall_valid", 32'(m_axis_valid), 32'd1);
                chk("stall_data", 32'(m_axis_data), 32'(pd));
            end
            if (m_axis_valid && m_axis_ready) begin
                chk("beat", 32'(m_axis_data), 32'(exp_px(bif)));
                rec[bif] = m_axis_data;
                bif = (bif + 1) % NPX;
                beats_total++;
            end
            if (o_busy) busy_cycles++;
            if (o_busy && !pb) busy_runs++;
            pv = m_axis_valid; pr = m_axis_ready; pd = m_axis_data; pb = o_busy;
        end
    end

    task automatic wb_xfer(input logic [4:0] adr, input logic we, input logic [31:0] wd,
                           output logic [31:0] rd);
        int n;
        @(posedge clk); #1;
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_i = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!wb_ack_o && n < 20);
        chk("wb_ack", 32'(wb_ack_o), 32'd1);
        rd = wb_dat_o;
        if (we && int'(adr) < NPX) m_px[adr[2:0]] = wd[23:0];
        if (we && adr == 5'h11 && BR_EN) m_bright = wd[7:0];
        @(posedge clk); #1;
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(negedge clk);
        chk("wb_ack_single", 32'(wb_ack_o), 32'd0);
    endtask

    task automatic wb_wr(input logic [4:0] adr, input logic [31:0] wd);
        logic [31:0] d;
        wb_xfer(adr, 1'b1, wd, d);
    endtask

    task automatic wb_rd_chk(input string nm, input logic [4:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(adr, 1'b0, '0, d);
        chk(nm, d, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 3000) begin @(negedge clk); n++; end
        chk("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    task automatic wait_bif(input int k);
        int n = 0;
        while (bif != k && n < 200) begin @(posedge clk); n++; end
        chk("beat_reach", 32'(bif), 32'(k));
    endtask

    typedef struct {
        logic [4:0]  adr;
        logic [31:0] wdat;
        logic [31:0] rexp;
    } vec_t;
    vec_t tbl [10];

    initial begin
        int b0, e0, frames, extras;
        tbl[0] = '{5'h00, 32'hFF00FF00, 32'h0000FF00};
        tbl[1] = '{5'h07, 32'h12ABCDEF, 32'h00ABCDEF};
        tbl[2] = '{5'h03, 32'hFFFFFFFF, 32'h00FFFFFF};
        tbl[3] = '{5'h08, 32'hDEADBEEF, 32'h00000000};
        tbl[4] = '{5'h0F, 32'h00000001, 32'h00000000};
        tbl[5] = '{5'h12, 32'h00000005, 32'h00000000};
        tbl[6] = '{5'h1F, 32'h00000007, 32'h00000000};
        tbl[7] = '{5'h11, 32'h000001A5, BR_EN ? 32'hA5 : 32'h0};
        tbl[8] = '{5'h10, 32'hFFFFFFFE, 32'h00000000};
        tbl[9] = '{5'h11, 32'h000000FF, BR_EN ? 32'hFF : 32'h0};
        for (int i = 0; i < NPX; i++) m_px[i] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(m_axis_valid), 32'd0);
        chk("rst_data", 32'(m_axis_data), 32'd0);
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_dat_o", wb_dat_o, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        axis_reset = 0;
        wb_rd_chk("rst_px2", 5'h02, 32'd0);
        wb_rd_chk("rst_ctrl", 5'h10, 32'd0);
        wb_rd_chk("rst_bright", 5'h11, BR_EN ? 32'hFF : 32'h0);

        for (int i = 0; i < 10; i++) begin
            wb_wr(tbl[i].adr, tbl[i].wdat);
            wb_rd_chk($sformatf("tbl%0d", i), tbl[i].adr, tbl[i].rexp);
        end
        chk("tbl_no_start", 32'(o_busy), 32'd0);

        // Single frame, ready tied high: 8 beats, busy for 8+LAT cycles.
        rdy_mode = 0;
        wb_wr(5'h00, 32'h0000FF00);
        for (int i = 1; i < NPX; i++) wb_wr(5'(i), 32'h0);
        b0 = beats_total; busy_cycles = 0;
        wb_wr(5'h10, 32'h1);
        wait_idle();
        chk("f1_beats", 32'(beats_total - b0), 32'(NPX));
        chk("f1_beat0", 32'(rec[0]), 32'h00FF00);
        chk("f1_busy_cycles", 32'(busy_cycles), 32'(NPX + LAT));

        // Ready toggling every cycle.
        rdy_mode = 1;
        for (int i = 0; i < NPX; i++) wb_wr(5'(i), 32'(24'h010203 * (i + 1)));
        b0 = beats_total;
        wb_wr(5'h10, 32'h1);
        wait_idle();
        chk("tog_beats", 32'(beats_total - b0), 32'(NPX));

        // Three starts during SEND coalesce into one back-to-back frame.
        rdy_mode = 0;
        b0 = beats_total; e0 = busy_runs; busy_cycles = 0;
        wb_wr(5'h10, 32'h1);
        repeat (3) wb_wr(5'h10, 32'h1);
        wb_rd_chk("pend_ctrl", 5'h10, 32'h3);
        wait_idle();
        chk("pend_beats", 32'(beats_total - b0), 32'(2 * NPX));
        chk("pend_one_run", 32'(busy_runs - e0), 32'd1);
        chk("pend_busy_cycles", 32'(busy_cycles), 32'(2 * (NPX + LAT)));
        wb_rd_chk("pend_clear", 5'h10, 32'h0);

        // Pixel 5 rewritten while idx=2 shows up in the current frame.
        rdy_mode = 3; man_ready = 0;
        wb_wr(5'h10, 32'h1);
        man_ready = 1;
        wait_bif(2);
        man_ready = 0;
        wb_wr(5'h05, 32'h00123456);
        man_ready = 1;
        wait_idle();
        chk("late_px5", 32'(rec[5]), 32'h123456);

`ifdef NEOPX_BRIGHTNESS_EN
        rdy_mode = 0;
        wb_wr(5'h11, 32'h7F);
        wb_wr(5'h00, 32'h00FF8040);
        wb_wr(5'h10, 32'h1);
        wait_idle();
        // (c*(BRIGHT+1))>>8 per byte with BRIGHT=0x7F
        chk("bright_beat0", 32'(rec[0]), 32'h7F4020);
        wb_wr(5'h11, 32'hFF);
`endif

        // Randomized frames against the model.
        for (int it = 0; it < 6; it++) begin
            rdy_mode = 2;
            for (int i = 0; i < NPX; i++) wb_wr(5'(i), $urandom);
            if (BR_EN) wb_wr(5'h11, 32'($urandom_range(0, 255)));
            extras = $urandom_range(0, 3);
            frames = (extras > 0) ? 2 : 1;
            b0 = beats_total;
            wb_wr(5'h10, 32'h1);
            for (int j = 0; j < extras; j++) wb_wr(5'h10, 32'h1);
            wait_idle();
            chk($sformatf("rnd%0d_beats", it), 32'(beats_total - b0), 32'(frames * NPX));
        end

        // Reset mid-SEND at idx=3 abandons the frame.
        rdy_mode = 3; man_ready = 0;
        wb_wr(5'h10, 32'h1);
        man_ready = 1;
        wait_bif(3);
        man_ready = 0;
        @(posedge clk); #2;
        axis_reset = 1;
        #1;
        chk("mid_rst_valid", 32'(m_axis_valid), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        for (int i = 0; i < NPX; i++) m_px[i] = '0;
        m_bright = 8'hFF;
        @(negedge clk); @(negedge clk);
        axis_reset = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(o_busy), 32'd0);
        chk("post_rst_valid", 32'(m_axis_valid), 32'd0);
        for (int i = 0; i < NPX; i++) wb_rd_chk($sformatf("post_rst_px%0d", i), 5'(i), 32'd0);
        wb_rd_chk("post_rst_ctrl", 5'h10, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
